// File: rtl/mips_multicycle_core_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_core_if
// Shared instruction/data memory port of the multi-cycle MIPS core.
//   mem_req   : request valid (master -> slave)
//   mem_we    : 1 = write, 0 = read, valid while mem_req = 1
//   mem_addr  : byte address (word aligned), ADDR_W bits
//   mem_wdata : store data
//   mem_ready : access completes this cycle (slave -> master)
//   mem_rdata : read data, valid in the cycle mem_ready = 1
// The request fields are held stable while mem_req = 1 and mem_ready = 0.
// -----------------------------------------------------------------------------
interface mips_multicycle_core_if #(
   parameter int ADDR_W = 10
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// -----------------------------------------------------------------------------
// mips_multicycle_core
// Multi-cycle MIPS-subset core (add/sub/and/or/slt/nor, addi, lw, sw, beq, j)
// sequenced by a FETCH/DECODE/EXEC/MEM/WB/HALT state machine over a single
// shared memory port with a req/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   mem       : memory port (mips_multicycle_core_if.master)
//   pc        : current program counter
//   retire    : one-cycle pulse when an instruction completes
//   halted    : core is in HALT (illegal instruction or misaligned lw/sw)
//   cycle_cnt : non-HALT cycle counter      (only with PERF_CNT_EN defined)
//   instr_cnt : retired instruction counter (only with PERF_CNT_EN defined)
// Optional feature macro: PERF_CNT_EN (adds the two performance counters).
// -----------------------------------------------------------------------------
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          ADDR_W          = 10,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_multicycle_core_if.master mem,
   output logic [31:0]           pc,
   output logic                  retire,
   output logic                  halted
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] rf_q [32];

   // Instruction fields
   logic [5:0]  op_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s;
   logic [31:0] sext_s, sum_s, rs_val_s, rt_val_s;
   logic        is_rtype_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, legal_s;
   logic        misaligned_s;
   logic        unused_shamt_s;

   // Register-file write port
   logic        rf_we_s;
   logic [4:0]  rf_wa_s;
   logic [31:0] rf_wd_s;

   // Output decode
   logic              mem_req_s, mem_we_s, retire_s, halted_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [31:0]       mem_wdata_s;

   // R-type ALU; slt compares as signed two's complement.
   function automatic logic [31:0] alu_f(input logic [5:0] fn,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      case (fn)
         6'b100000: r = x + y;
         6'b100010: r = x - y;
         6'b100100: r = x & y;
         6'b100101: r = x | y;
         6'b101010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         6'b100111: r = ~(x | y);
         default:   r = 32'd0;
      endcase
      return r;
   endfunction

   assign op_s           = ir_q[31:26];
   assign rs_s           = ir_q[25:21];
   assign rt_s           = ir_q[20:16];
   assign rd_s           = ir_q[15:11];
   assign funct_s        = ir_q[5:0];
   assign unused_shamt_s = ^ir_q[10:6];
   assign sext_s         = {{16{ir_q[15]}}, ir_q[15:0]};
   assign sum_s          = a_q + sext_s;
   assign misaligned_s   = (sum_s[1:0] != 2'b00);
   // Register 0 is never written, but force the zero read explicitly anyway.
   assign rs_val_s       = (rs_s == 5'd0) ? 32'd0 : rf_q[rs_s];
   assign rt_val_s       = (rt_s == 5'd0) ? 32'd0 : rf_q[rt_s];

   // Instruction class decode from IR
   always_comb begin
      is_rtype_s = 1'b0;
      is_addi_s  = 1'b0;
      is_lw_s    = 1'b0;
      is_sw_s    = 1'b0;
      is_beq_s   = 1'b0;
      is_j_s     = 1'b0;
      case (op_s)
         6'b000000: begin
            case (funct_s)
               6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b101010, 6'b100111: is_rtype_s = 1'b1;
               default:                         is_rtype_s = 1'b0;
            endcase
         end
         6'b001000: is_addi_s = 1'b1;
         6'b100011: is_lw_s   = 1'b1;
         6'b101011: is_sw_s   = 1'b1;
         6'b000100: is_beq_s  = 1'b1;
         6'b000010: is_j_s    = 1'b1;
         default:   is_rtype_s = 1'b0;
      endcase
      legal_s = is_rtype_s | is_addi_s | is_lw_s | is_sw_s | is_beq_s | is_j_s;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem.mem_ready) state_d = S_DECODE;
            else               state_d = S_FETCH;
         end
         S_DECODE: begin
            if (is_j_s)               state_d = S_FETCH;
            else if (!legal_s)        state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            else                      state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_rtype_s || is_addi_s)  state_d = S_WB;
            else if (is_lw_s || is_sw_s)  state_d = misaligned_s ? S_HALT : S_MEM;
            else                          state_d = S_FETCH;
         end
         S_MEM: begin
            if (mem.mem_ready) state_d = is_lw_s ? S_WB : S_FETCH;
            else               state_d = S_MEM;
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   // FSM output decode: memory request, retire pulse, halt flag
   always_comb begin
      mem_req_s   = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = 32'd0;
      retire_s    = 1'b0;
      halted_s    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s  = 1'b1;
            mem_addr_s = pc_q[ADDR_W-1:0];
         end
         S_DECODE: retire_s = is_j_s | (~legal_s & ~HALT_ON_ILLEGAL);
         S_EXEC:   retire_s = is_beq_s;
         S_MEM: begin
            mem_req_s   = 1'b1;
            mem_we_s    = is_sw_s;
            mem_addr_s  = alu_q[ADDR_W-1:0];
            mem_wdata_s = b_q;
            retire_s    = mem.mem_ready & is_sw_s;
         end
         S_WB:    retire_s = 1'b1;
         S_HALT:  halted_s = 1'b1;
         default: halted_s = 1'b0;
      endcase
   end

   // The FSM resets into FETCH, so the request must be masked during reset.
   assign mem.mem_req   = mem_req_s & ~reset;
   assign mem.mem_we    = mem_we_s;
   assign mem.mem_addr  = mem_addr_s;
   assign mem.mem_wdata = mem_wdata_s;
   assign pc            = pc_q;
   assign retire        = retire_s;
   assign halted        = halted_s;

   // Datapath next-state: PC, IR, A/B, ALUOut, MDR
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      a_d   = a_q;
      b_d   = b_q;
      alu_d = alu_q;
      mdr_d = mdr_q;
      case (state_q)
         S_FETCH: begin
            if (mem.mem_ready) begin
               ir_d = mem.mem_rdata;
               pc_d = pc_q + 32'd4;
            end else begin
               ir_d = ir_q;
            end
         end
         S_DECODE: begin
            a_d   = rs_val_s;
            b_d   = rt_val_s;
            // Branch target precomputed from the already incremented PC.
            alu_d = pc_q + {sext_s[29:0], 2'b00};
            if (is_j_s) pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            else        pc_d = pc_q;
         end
         S_EXEC: begin
            if (is_rtype_s)                            alu_d = alu_f(funct_s, a_q, b_q);
            else if (is_addi_s || is_lw_s || is_sw_s)  alu_d = sum_s;
            else if (is_beq_s && (a_q == b_q))         pc_d  = alu_q;
            else                                       pc_d  = pc_q;
         end
         S_MEM: begin
            if (mem.mem_ready && is_lw_s) mdr_d = mem.mem_rdata;
            else                          mdr_d = mdr_q;
         end
         default: pc_d = pc_q;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= 32'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         alu_q <= 32'd0;
         mdr_q <= 32'd0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         a_q   <= a_d;
         b_q   <= b_d;
         alu_q <= alu_d;
         mdr_q <= mdr_d;
      end
   end

   // Write-back port selection; writes to register 0 are dropped here.
   always_comb begin
      rf_wa_s = 5'd0;
      rf_wd_s = 32'd0;
      if (state_q == S_WB) begin
         if (is_rtype_s) begin
            rf_wa_s = rd_s;
            rf_wd_s = alu_q;
         end else if (is_lw_s) begin
            rf_wa_s = rt_s;
            rf_wd_s = mdr_q;
         end else begin
            rf_wa_s = rt_s;
            rf_wd_s = alu_q;
         end
      end else begin
         rf_wa_s = 5'd0;
      end
      rf_we_s = (state_q == S_WB) && (rf_wa_s != 5'd0);
   end

   // Register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (rf_we_s) begin
         rf_q[rf_wa_s] <= rf_wd_s;
      end else begin
         rf_q[0] <= 32'd0;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q;

   // Performance counters: active cycles and retired instructions
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q <= 32'd0;
         instr_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q <= (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
         instr_cnt_q <= retire_s ? instr_cnt_q + 32'd1 : instr_cnt_q;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_core
// Scoreboard bench: each test loads a small program, queues the memory
// transfers and retire cycles it must produce, and a monitor process pops and
// compares them as the core presents transfers / retire pulses.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_core;

   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        retire, halted;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   mips_multicycle_core_if #(.ADDR_W(10)) bus ();

   mips_multicycle_core #(
      .RESET_PC(32'h0000_0000), .ADDR_W(10), .HALT_ON_ILLEGAL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .mem(bus), .pc(pc), .retire(retire), .halted(halted)
`ifdef PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: program image + data overlay, programmable wait states
   logic [31:0] imem [256];
   logic [31:0] dmem [256];
   logic [255:0] dvalid;
   int          wait_cycles;
   int          wcnt;
   int          cycle_no;

   always_comb begin
      bus.mem_ready = bus.mem_req && (wcnt == wait_cycles);
      bus.mem_rdata = dvalid[bus.mem_addr[9:2]] ? dmem[bus.mem_addr[9:2]] : imem[bus.mem_addr[9:2]];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) wcnt <= 0;
      else if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   always @(posedge clk) begin
      if (reset) dvalid <= '0;
      else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
         dmem[bus.mem_addr[9:2]]   <= bus.mem_wdata;
         dvalid[bus.mem_addr[9:2]] <= 1'b1;
      end
   end

   // Cycle 1 is the first cycle after reset release
   always @(posedge clk or posedge reset) begin
      if (reset) cycle_no <= 1;
      else cycle_no <= cycle_no + 1;
   end

   // Scoreboard state
   xfer_t exp_q [$];
   int    ret_q [$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    test_id = 0;
   logic  chk_end = 1'b0;
   logic  exp_halt = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s (test %0d, cycle %0d): got %h, expected %h", name, test_id, cycle_no, act, exp);
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   initial begin
      bit          pend;
      logic        s_we;
      logic [9:0]  s_addr;
      logic [31:0] s_wdata;
      xfer_t       x;
      int          r;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 1'b0;
            chk(pc == 32'h0, "rst_pc", pc, 32'h0);
            chk(bus.mem_req == 1'b0, "rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk(retire == 1'b0 && halted == 1'b0, "rst_retire_halted", {30'd0, retire, halted}, 32'd0);
         end else begin
            if (pend) begin
               chk(bus.mem_req && bus.mem_we == s_we && bus.mem_addr == s_addr && bus.mem_wdata == s_wdata,
                   "req_stable", {bus.mem_req, bus.mem_we, 20'd0, bus.mem_addr}, {1'b1, s_we, 20'd0, s_addr});
            end
            pend    = bus.mem_req && !bus.mem_ready;
            s_we    = bus.mem_we;
            s_addr  = bus.mem_addr;
            s_wdata = bus.mem_wdata;
            if (bus.mem_req && bus.mem_ready) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_xfer", {21'd0, bus.mem_we, bus.mem_addr}, 32'd0);
               end else begin
                  x = exp_q.pop_front();
                  chk(bus.mem_we == x.we && bus.mem_addr == x.addr, "xfer_addr",
                      {21'd0, bus.mem_we, bus.mem_addr}, {21'd0, x.we, x.addr});
                  if (x.we) chk(bus.mem_wdata == x.data, "xfer_wdata", bus.mem_wdata, x.data);
               end
            end
            if (retire) begin
               if (ret_q.size() == 0) begin
                  chk(1'b0, "unexpected_retire", cycle_no, 32'd0);
               end else begin
                  r = ret_q.pop_front();
                  chk(cycle_no == r, "retire_cycle", cycle_no, r);
               end
            end
            if (halted) chk(bus.mem_req == 1'b0, "halt_no_req", {31'd0, bus.mem_req}, 32'd0);
`ifdef PERF_CNT_EN
            if (test_id == 1 && cycle_no == 13) begin
               chk(instr_cnt == 32'd3, "instr_cnt", instr_cnt, 32'd3);
               chk(cycle_cnt == 32'd12, "cycle_cnt", cycle_cnt, 32'd12);
            end
`endif
         end
         if (chk_end) begin
            chk(halted == exp_halt, "halted_end", {31'd0, halted}, {31'd0, exp_halt});
            chk(exp_q.size() == 0, "xfers_missing", exp_q.size(), 32'd0);
            chk(ret_q.size() == 0, "retires_missing", ret_q.size(), 32'd0);
         end
      end
   end

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'b000010, t};
   endfunction

   task automatic put(input logic [9:0] a, input logic [31:0] w);
      imem[a[9:2]] = w;
   endtask
   // Place an instruction that must be fetched, in program order
   task automatic ins(input logic [9:0] a, input logic [31:0] w);
      put(a, w);
      exp_q.push_back('{1'b0, a, 32'd0});
   endtask
   task automatic ew(input logic [9:0] a, input logic [31:0] d);
      exp_q.push_back('{1'b1, a, d});
   endtask
   task automatic er(input logic [9:0] a);
      exp_q.push_back('{1'b0, a, 32'd0});
   endtask

   task automatic begin_test(input int id, input int waits);
      @(posedge clk); #1;
      reset       = 1'b1;
      test_id     = id;
      wait_cycles = waits;
      exp_halt    = 1'b1;
      exp_q.delete();
      ret_q.delete();
      for (int i = 0; i < 256; i++) imem[i] = 32'd0;
   endtask

   task automatic run_to_halt(input int max_cyc);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < max_cyc && !halted; i++) begin
         @(posedge clk); #1;
      end
      repeat (8) @(posedge clk);
      #1 chk_end = 1'b1;
      @(posedge clk); #1 chk_end = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wait_cycles = 0;

      // Test 1: ALU ops, $0 discard, stores, zero-wait retire timing
      begin_test(1, 0);
      ins(10'h000, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
      ins(10'h004, enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD));
      ins(10'h008, enc_r(5'd1, 5'd2, 5'd3, F_ADD));
      ins(10'h00C, enc_r(5'd2, 5'd1, 5'd4, F_SLT));
      ins(10'h010, enc_r(5'd0, 5'd0, 5'd5, F_NOR));
      ins(10'h014, enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7));
      ins(10'h018, enc_r(5'd0, 5'd0, 5'd7, F_ADD));
      ins(10'h01C, enc_r(5'd1, 5'd2, 5'd8, F_SUB));
      ins(10'h020, enc_r(5'd1, 5'd2, 5'd9, F_AND));
      ins(10'h024, enc_r(5'd1, 5'd2, 5'd10, F_OR));
      ins(10'h028, enc_r(5'd1, 5'd2, 5'd11, F_SLT));
      ins(10'h02C, enc_i(OP_SW, 5'd0, 5'd3, 16'h0100));  ew(10'h100, 32'd2);
      ins(10'h030, enc_i(OP_SW, 5'd0, 5'd4, 16'h0104));  ew(10'h104, 32'd1);
      ins(10'h034, enc_i(OP_SW, 5'd0, 5'd5, 16'h0108));  ew(10'h108, 32'hFFFF_FFFF);
      ins(10'h038, enc_i(OP_SW, 5'd0, 5'd7, 16'h010C));  ew(10'h10C, 32'd0);
      ins(10'h03C, enc_i(OP_SW, 5'd0, 5'd8, 16'h0110));  ew(10'h110, 32'd8);
      ins(10'h040, enc_i(OP_SW, 5'd0, 5'd9, 16'h0114));  ew(10'h114, 32'd5);
      ins(10'h044, enc_i(OP_SW, 5'd0, 5'd10, 16'h0118)); ew(10'h118, 32'hFFFF_FFFD);
      ins(10'h048, enc_i(OP_SW, 5'd0, 5'd11, 16'h011C)); ew(10'h11C, 32'd0);
      ins(10'h04C, ILLEGAL);
      for (int k = 1; k <= 19; k++) ret_q.push_back(4 * k);
      run_to_halt(200);

      // Test 2: sw/lw with 3 wait states on every access (lw = 11 cycles)
      begin_test(2, 3);
      ins(10'h000, enc_j(26'h10));
      ins(10'h040, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
      ins(10'h044, enc_i(OP_SW, 5'd0, 5'd1, 16'd8));  ew(10'h008, 32'd5);
      ins(10'h048, enc_i(OP_LW, 5'd0, 5'd6, 16'd8));  er(10'h008);
      ins(10'h04C, enc_i(OP_SW, 5'd0, 5'd6, 16'hC));  ew(10'h00C, 32'd5);
      ins(10'h050, ILLEGAL);
      ret_q.push_back(5);  ret_q.push_back(12); ret_q.push_back(22);
      ret_q.push_back(33); ret_q.push_back(43);
      run_to_halt(300);

      // Test 3: beq taken / not taken, j with pc[31:28] splice
      begin_test(3, 0);
      ins(10'h000, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
      ins(10'h004, enc_j(26'h4));
      ins(10'h010, enc_i(OP_BEQ, 5'd1, 5'd1, 16'd2));
      put(10'h014, enc_i(OP_SW, 5'd0, 5'd1, 16'h0090));
      put(10'h018, enc_i(OP_SW, 5'd0, 5'd1, 16'h0094));
      ins(10'h01C, enc_i(OP_BEQ, 5'd1, 5'd0, 16'd5));
      ins(10'h020, enc_j(26'h40));
      ins(10'h100, enc_i(OP_SW, 5'd0, 5'd1, 16'h0080)); ew(10'h080, 32'd1);
      ins(10'h104, ILLEGAL);
      ret_q.push_back(4);  ret_q.push_back(6);  ret_q.push_back(9);
      ret_q.push_back(12); ret_q.push_back(14); ret_q.push_back(18);
      run_to_halt(200);

      // Test 4: misaligned lw halts without a data request
      begin_test(4, 0);
      ins(10'h000, enc_i(OP_LW, 5'd0, 5'd2, 16'd6));
      put(10'h004, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
      run_to_halt(50);

      // Test 5: reset asserted during a waited fetch at pc 4
      begin_test(5, 3);
      ins(10'h000, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
      put(10'h004, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2));
      ret_q.push_back(7);
      exp_halt = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk_end = 1'b1;
      @(posedge clk);
      #1 chk_end = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
